// File: rtl/bcd_pkg.sv
// Shared BCD arithmetic types and constants for the digit-serial datapath.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_RADIX   = 10;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtract with borrow: d = x - y - bin, folded back into 0..9.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       bin,
  output bcd_digit_t d,
  output logic       bout
);

  logic [BCD_DIGIT_W:0] t;

  // Bit 4 of the 5-bit difference is the sign, i.e. the outgoing borrow.
  assign t    = {1'b0, x} - {1'b0, y} - {{BCD_DIGIT_W{1'b0}}, bin};
  assign bout = t[BCD_DIGIT_W];
  assign d    = bout ? (t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_RADIX)) : t[BCD_DIGIT_W-1:0];

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial |A-B| for packed BCD, LSD first, with a ten's-complement fix-up pass.
// Optional invalid-nibble detection and err port when BCD_INVALID_CHECK_EN is defined.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [BCD_DIGIT_W*N_DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*N_DIGITS-1:0] b,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*N_DIGITS-1:0] diff,
  output logic                            neg
`ifdef BCD_INVALID_CHECK_EN
  ,
  output logic                            err
`endif
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  state_t                            state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic                              borrow_q, borrow_d;
  logic                              neg_q, neg_d;
  logic [BCD_DIGIT_W*N_DIGITS-1:0]   a_q, a_d, b_q, b_d;
  bcd_digit_t                        diff_q [N_DIGITS];
  bcd_digit_t                        diff_d [N_DIGITS];
  bcd_digit_t                        a_dig  [N_DIGITS];
  bcd_digit_t                        b_dig  [N_DIGITS];

  bcd_digit_t x_w, y_w, d_w;
  logic       bout_w;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_dig
      assign a_dig[gi] = a_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
      assign b_dig[gi] = b_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
      assign diff[gi*BCD_DIGIT_W +: BCD_DIGIT_W] = diff_q[gi];
    end
  endgenerate

  // FIX pass reuses the same digit slice as 0 - r_i - borrow.
  assign x_w = (state_q == FIX) ? '0 : a_dig[idx_q];
  assign y_w = (state_q == FIX) ? diff_q[idx_q] : b_dig[idx_q];

  bcd_digit_sub u_digit_sub (
    .x   (x_w),
    .y   (y_w),
    .bin (borrow_q),
    .d   (d_w),
    .bout(bout_w)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          for (int i = 0; i < N_DIGITS; i++) diff_d[i] = '0;
          idx_d    = '0;
          borrow_d = 1'b0;
          neg_d    = 1'b0;
          state_d  = SUB;
        end
      end
      SUB, FIX: begin
        diff_d[idx_q] = d_w;
        borrow_d      = bout_w;
        idx_d         = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          borrow_d = 1'b0;
          if (state_q == FIX) begin
            neg_d   = 1'b1;
            state_d = DONE;
          end else if (bout_w) begin
            state_d = FIX;
          end else begin
            neg_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      for (int i = 0; i < N_DIGITS; i++) diff_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
    end
  end

  assign busy = (state_q == SUB) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign neg  = neg_q;

`ifdef BCD_INVALID_CHECK_EN
  logic [N_DIGITS-1:0] nib_bad;
  logic                err_q, err_d;

  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_chk
      assign nib_bad[gi] = (a[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_RADIX - 1)) ||
                           (b[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_RADIX - 1));
    end
  endgenerate

  // Sampled only at the accepting start; held until the next acceptance.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start) err_d = |nib_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed self-checking bench for bcd_serial_subtractor (N_DIGITS=4).
module tb_bcd_serial_subtractor;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, neg;
  logic [15:0] diff;
`ifdef BCD_INVALID_CHECK_EN
  logic        err;
`endif

  int checks = 0;
  int failures = 0;

  bcd_serial_subtractor #(.N_DIGITS(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff),
    .neg  (neg)
`ifdef BCD_INVALID_CHECK_EN
    ,
    .err  (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulses start for one cycle, scrambles operands afterwards, waits (bounded) for done.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                       output int lat, output int bcnt);
    bit seen;
    seen = 0;
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 16'h5555;
      b = 16'h3333;
      if (busy) bcnt++;
      if (done) begin
        seen = 1;
        lat  = c;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp_diff, input logic exp_neg,
                        input int exp_lat, input int exp_busy);
    int lat, bcnt;
    do_op(av, bv, lat, bcnt);
    $display("op %s a=%h b=%h diff=%h neg=%b lat=%0d busy_cycles=%0d",
             tag, av, bv, diff, neg, lat, bcnt);
    check($sformatf("%s_lat", tag), lat, exp_lat);
    check($sformatf("%s_diff", tag), diff, exp_diff);
    check($sformatf("%s_neg", tag), neg, exp_neg);
    check($sformatf("%s_busy", tag), bcnt, exp_busy);
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("%s_done_pulse", tag), done, 1'b0);
    check($sformatf("%s_hold", tag), {neg, diff}, {exp_neg, exp_diff});
  endtask

  initial begin
    int lat, bcnt, dcount;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 16'h0000);
    check("rst_neg", neg, 1'b0);
`ifdef BCD_INVALID_CHECK_EN
    check("rst_err", err, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op("pos",      16'h1234, 16'h0567, 16'h0667, 1'b0, 5, 4);
    run_op("negv",     16'h0567, 16'h1234, 16'h0667, 1'b1, 9, 8);
    run_op("zm1",      16'h0000, 16'h0001, 16'h0001, 1'b1, 9, 8);
    run_op("eq",       16'h9999, 16'h9999, 16'h0000, 1'b0, 5, 4);
    run_op("borrowch", 16'h1000, 16'h0001, 16'h0999, 1'b0, 5, 4);
    run_op("negch",    16'h0001, 16'h1000, 16'h0999, 1'b1, 9, 8);
    run_op("maxpos",   16'h9999, 16'h0000, 16'h9999, 1'b0, 5, 4);
    run_op("maxneg",   16'h0000, 16'h9999, 16'h9999, 1'b1, 9, 8);

    // Re-pulse start while busy: must be ignored, single done.
    @(negedge clk);
    a = 16'h1234;
    b = 16'h0567;
    start = 1'b1;
    dcount = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      start = (c == 2);
      a = (c == 2) ? 16'h0001 : 16'h5555;
      b = (c == 2) ? 16'h9000 : 16'h3333;
      if (done) begin
        dcount++;
        check("repulse_diff", diff, 16'h0667);
        check("repulse_neg", neg, 1'b0);
      end
    end
    start = 1'b0;
    $display("op repulse done_pulses=%0d diff=%h neg=%b", dcount, diff, neg);
    check("repulse_dcount", dcount, 1);

    // Reset mid-SUB aborts: outputs cleared, no done afterwards.
    @(negedge clk);
    a = 16'h0567;
    b = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", diff, 16'h0000);
    check("abort_neg", neg, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) dcount++;
    end
    $display("op abort activity_after_reset=%0d", dcount);
    check("abort_no_done", dcount, 0);

    run_op("after_rst", 16'h0500, 16'h0250, 16'h0250, 1'b0, 5, 4);

`ifdef BCD_INVALID_CHECK_EN
    do_op(16'h12A4, 16'h0001, lat, bcnt);
    $display("op invalid a=12a4 err=%b", err);
    check("err_set", err, 1'b1);
    do_op(16'h0042, 16'h0001, lat, bcnt);
    $display("op valid_after_invalid err=%b diff=%h", err, diff);
    check("err_clear", err, 1'b0);
    check("err_clear_diff", diff, 16'h0041);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
